// File: rtl/fdct_sched_pkg.sv
// Shared types and defaults for the fdct_quant macroblock scheduler.
// Picture-size widths follow the global MB-count macros unless overridden.
`ifndef W_PWInMbsM1
`define W_PWInMbsM1 7
`endif
`ifndef W_PHInMbsM1
`define W_PHInMbsM1 7
`endif

package fdct_sched_pkg;

  localparam int W_COL_DEF     = `W_PWInMbsM1 + 1;
  localparam int W_ROW_DEF     = `W_PHInMbsM1 + 1;
  localparam int EE_SLOTS_DEF  = 2;
  localparam int ROW_SLOTS_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN,
    ST_DRAIN
  } sched_state_t;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fdct_sched_if.sv
// Scheduler bus: picture control, camera/ee credit pulses and the MB issue signals.
// master = the scheduler, slave = the surrounding capture / fdct_quant / encoder side.
interface fdct_sched_if
  import fdct_sched_pkg::*;
#(
  parameter int W_COL = W_COL_DEF,
  parameter int W_ROW = W_ROW_DEF
);
  logic             pic_start;
  logic [W_COL-1:0] pic_w_mbs_m1;
  logic [W_ROW-1:0] pic_h_mbs_m1;
  logic             row_avail;
  logic             ready_for_next;
  logic             wr_ee_buf_ready;
  logic             ee_slot_free;
  logic             fdct_go;
  logic [W_COL-1:0] MB_Col;
  logic [W_ROW-1:0] MB_Row;
  logic             last_mb_in_row;
  logic             last_mb_in_pic;
  logic             row_release;
  logic             pic_done;
  logic             busy;
  logic             err_row_ovf;

  modport master (
    input  pic_start, pic_w_mbs_m1, pic_h_mbs_m1, row_avail,
           ready_for_next, wr_ee_buf_ready, ee_slot_free,
    output fdct_go, MB_Col, MB_Row, last_mb_in_row, last_mb_in_pic,
           row_release, pic_done, busy, err_row_ovf
  );

  modport slave (
    output pic_start, pic_w_mbs_m1, pic_h_mbs_m1, row_avail,
           ready_for_next, wr_ee_buf_ready, ee_slot_free,
    input  fdct_go, MB_Col, MB_Row, last_mb_in_row, last_mb_in_pic,
           row_release, pic_done, busy, err_row_ovf
  );
endinterface

// File: rtl/fdct_sched_sat_credit_cnt.sv
// Saturating credit counter: +1 on inc, -1 on dec, both together hold.
// An increment at MAX holds the count and sets a sticky overflow flag.
module sat_credit_cnt #(
  parameter int MAX  = 2,
  parameter int INIT = 0,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         ovf
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= W'(INIT);
      ovf   <= 1'b0;
    end else if (inc && !dec) begin
      if (count == W'(MAX)) ovf <= 1'b1;
      else                  count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fdct_sched.sv
// Raster-order macroblock scheduler: issues fdct_go per MB once a camera row
// is resident and an ee_buf slot is free, then drains outstanding writes.
//   state    | meaning
//   ST_IDLE  | no picture; rows may pre-fill the camera buffer
//   ST_WAIT  | next MB indexed, waiting for row and ee credit
//   ST_RUN   | MB issued, waiting for fdct_quant to finish camera reads
//   ST_DRAIN | last MB read, waiting for all ee_buf writes to land
module fdct_sched
  import fdct_sched_pkg::*;
#(
  parameter int W_COL     = W_COL_DEF,
  parameter int W_ROW     = W_ROW_DEF,
  parameter int EE_SLOTS  = EE_SLOTS_DEF,
  parameter int ROW_SLOTS = ROW_SLOTS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  fdct_sched_if.master bus
);

  localparam int RC_W  = cnt_width(ROW_SLOTS);
  localparam int EC_W  = cnt_width(EE_SLOTS);
  localparam int OUT_W = cnt_width(EE_SLOTS);

  sched_state_t      state;
  logic [W_COL-1:0]  pic_w, mb_col, next_col;
  logic [W_ROW-1:0]  pic_h, mb_row, next_row;
  logic              last_row_q, last_pic_q;
  logic              go_q, release_q, done_q, busy_q;
  logic [RC_W-1:0]   row_credit;
  logic [EC_W-1:0]   ee_credit;
  logic [OUT_W-1:0]  outstanding;
  logic              row_ovf, ee_ovf_unused;
  logic              issue, row_done, wr_done;

  assign issue    = (state == ST_WAIT) && (row_credit != '0) && (ee_credit != '0);
  assign row_done = (state == ST_RUN) && bus.ready_for_next && last_row_q;
  assign wr_done  = bus.wr_ee_buf_ready && (outstanding != '0);

  sat_credit_cnt #(.MAX(ROW_SLOTS), .INIT(0)) u_row_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.row_avail),
    .dec   (row_done),
    .count (row_credit),
    .ovf   (row_ovf)
  );

  sat_credit_cnt #(.MAX(EE_SLOTS), .INIT(EE_SLOTS)) u_ee_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.ee_slot_free),
    .dec   (issue),
    .count (ee_credit),
    .ovf   (ee_ovf_unused)
  );

  // Every outstanding MB holds an ee credit, so EE_SLOTS bounds this count.
  always_ff @(posedge clk) begin
    if (rst)                   outstanding <= '0;
    else if (issue && !wr_done) outstanding <= outstanding + 1'b1;
    else if (wr_done && !issue) outstanding <= outstanding - 1'b1;
  end

  always_comb begin
    next_col = mb_col + 1'b1;
    next_row = mb_row;
    if (last_row_q) begin
      next_col = '0;
      next_row = mb_row + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pic_w      <= '0;
      pic_h      <= '0;
      mb_col     <= '0;
      mb_row     <= '0;
      last_row_q <= 1'b0;
      last_pic_q <= 1'b0;
      go_q       <= 1'b0;
      release_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      go_q      <= 1'b0;
      release_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (bus.pic_start && !busy_q) begin
            busy_q     <= 1'b1;
            state      <= ST_WAIT;
            pic_w      <= bus.pic_w_mbs_m1;
            pic_h      <= bus.pic_h_mbs_m1;
            mb_col     <= '0;
            mb_row     <= '0;
            last_row_q <= (bus.pic_w_mbs_m1 == '0);
            last_pic_q <= (bus.pic_w_mbs_m1 == '0) && (bus.pic_h_mbs_m1 == '0);
          end
        end
        ST_WAIT: begin
          if (issue) begin
            go_q  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.ready_for_next) begin
            release_q <= last_row_q;
            // Indices stay on the final MB through drain.
            if (last_pic_q) begin
              state <= ST_DRAIN;
            end else begin
              state      <= ST_WAIT;
              mb_col     <= next_col;
              mb_row     <= next_row;
              last_row_q <= (next_col == pic_w);
              last_pic_q <= (next_col == pic_w) && (next_row == pic_h);
            end
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.fdct_go        = go_q;
  assign bus.MB_Col         = mb_col;
  assign bus.MB_Row         = mb_row;
  assign bus.last_mb_in_row = last_row_q;
  assign bus.last_mb_in_pic = last_pic_q;
  assign bus.row_release    = release_q;
  assign bus.pic_done       = done_q;
  assign bus.busy           = busy_q;
  assign bus.err_row_ovf    = row_ovf;

endmodule

// File: tb/tb_fdct_sched.sv
// Directed bench for fdct_sched: table of whole pictures with expected MB order,
// plus hand sequences for credit stalls, overflow, simultaneous credit and reset.
module tb_fdct_sched;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   go_cnt  = 0;
  int   rel_cnt = 0;
  int   done_cnt = 0;
  logic [17:0] got_q[$];

  fdct_sched_if bus ();

  fdct_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (bus.fdct_go)     go_cnt++;
    if (bus.row_release) rel_cnt++;
    if (bus.pic_done)    done_cnt++;
  end

  typedef struct {
    logic [7:0] w_m1;
    logic [7:0] h_m1;
    int         n_go;
    int         n_rel;
    int         go_idx;
  } pic_vec_t;

  typedef struct {
    logic [7:0] col;
    logic [7:0] row;
    logic       lr;
    logic       lp;
  } go_vec_t;

  pic_vec_t pics[5];
  go_vec_t  gos[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_pic(input logic [7:0] w, input logic [7:0] h);
    bus.pic_w_mbs_m1 = w;
    bus.pic_h_mbs_m1 = h;
    bus.pic_start    = 1'b1;
    tick();
    bus.pic_start    = 1'b0;
  endtask

  task automatic pulse_row();
    bus.row_avail = 1'b1;
    tick();
    bus.row_avail = 1'b0;
  endtask

  // fdct_quant finishes reads, then writes; encoder optionally frees the slot.
  task automatic mb_hs(input bit do_free);
    bus.ready_for_next  = 1'b1;
    tick();
    bus.ready_for_next  = 1'b0;
    bus.wr_ee_buf_ready = 1'b1;
    tick();
    bus.wr_ee_buf_ready = 1'b0;
    if (do_free) begin
      bus.ee_slot_free = 1'b1;
      tick();
      bus.ee_slot_free = 1'b0;
    end
  endtask

  task automatic wait_go(input int target, input string name);
    int n;
    n = 0;
    while (go_cnt < target && n < 100) begin
      tick();
      n++;
    end
    chk(name, go_cnt, target);
  endtask

  // Reactive environment: reads done 2 cycles after go, write 2 later, slot free 10 after write.
  task automatic run_pic(input logic [7:0] w, input logic [7:0] h,
                         output int n_go, output int n_rel, output int n_done,
                         output bit timeout);
    int cyc, rows_sent, rows_total;
    int rfn_q[$], wr_q[$], fr_q[$];
    bit done_seen, row_pending;
    n_go = 0; n_rel = 0; n_done = 0;
    cyc = 0; rows_sent = 0; rows_total = int'(h) + 1;
    done_seen = 1'b0; row_pending = 1'b0;
    got_q.delete();
    while (rows_sent < rows_total && rows_sent < 2) begin
      pulse_row();
      rows_sent++;
    end
    start_pic(w, h);
    while (!(done_seen && rfn_q.size() == 0 && wr_q.size() == 0 && fr_q.size() == 0)
           && cyc < 800) begin
      if (bus.fdct_go) begin
        got_q.push_back({bus.MB_Col, bus.MB_Row, bus.last_mb_in_row, bus.last_mb_in_pic});
        n_go++;
        rfn_q.push_back(cyc + 2);
        wr_q.push_back(cyc + 4);
        fr_q.push_back(cyc + 14);
      end
      if (bus.row_release) begin
        n_rel++;
        if (rows_sent < rows_total) begin
          row_pending = 1'b1;
          rows_sent++;
        end
      end
      if (bus.pic_done) begin
        n_done++;
        done_seen = 1'b1;
      end
      bus.ready_for_next  = 1'b0;
      bus.wr_ee_buf_ready = 1'b0;
      bus.ee_slot_free    = 1'b0;
      if (rfn_q.size() > 0 && rfn_q[0] == cyc) begin bus.ready_for_next  = 1'b1; void'(rfn_q.pop_front()); end
      if (wr_q.size()  > 0 && wr_q[0]  == cyc) begin bus.wr_ee_buf_ready = 1'b1; void'(wr_q.pop_front());  end
      if (fr_q.size()  > 0 && fr_q[0]  == cyc) begin bus.ee_slot_free    = 1'b1; void'(fr_q.pop_front());  end
      bus.row_avail = row_pending;
      row_pending   = 1'b0;
      tick();
      cyc++;
    end
    bus.ready_for_next  = 1'b0;
    bus.wr_ee_buf_ready = 1'b0;
    bus.ee_slot_free    = 1'b0;
    bus.row_avail       = 1'b0;
    timeout = !done_seen;
  endtask

  initial begin
    int ngo, nrel, ndone, base, rbase, dbase, n;
    bit to;

    pics[0] = '{8'd1, 8'd1, 4, 2, 0};   // 2x2
    pics[1] = '{8'd2, 8'd0, 3, 1, 4};   // 3x1
    pics[2] = '{8'd0, 8'd0, 1, 1, 7};   // 1x1
    pics[3] = '{8'd0, 8'd1, 2, 2, 8};   // 1x2
    pics[4] = '{8'd1, 8'd2, 6, 3, 10};  // 2x3, third row arrives after first release
    gos[0]  = '{8'd0, 8'd0, 1'b0, 1'b0};
    gos[1]  = '{8'd1, 8'd0, 1'b1, 1'b0};
    gos[2]  = '{8'd0, 8'd1, 1'b0, 1'b0};
    gos[3]  = '{8'd1, 8'd1, 1'b1, 1'b1};
    gos[4]  = '{8'd0, 8'd0, 1'b0, 1'b0};
    gos[5]  = '{8'd1, 8'd0, 1'b0, 1'b0};
    gos[6]  = '{8'd2, 8'd0, 1'b1, 1'b1};
    gos[7]  = '{8'd0, 8'd0, 1'b1, 1'b1};
    gos[8]  = '{8'd0, 8'd0, 1'b1, 1'b0};
    gos[9]  = '{8'd0, 8'd1, 1'b1, 1'b1};
    gos[10] = '{8'd0, 8'd0, 1'b0, 1'b0};
    gos[11] = '{8'd1, 8'd0, 1'b1, 1'b0};
    gos[12] = '{8'd0, 8'd1, 1'b0, 1'b0};
    gos[13] = '{8'd1, 8'd1, 1'b1, 1'b0};
    gos[14] = '{8'd0, 8'd2, 1'b0, 1'b0};
    gos[15] = '{8'd1, 8'd2, 1'b1, 1'b1};

    rst = 1'b1;
    bus.pic_start = 1'b0; bus.pic_w_mbs_m1 = '0; bus.pic_h_mbs_m1 = '0;
    bus.row_avail = 1'b0; bus.ready_for_next = 1'b0;
    bus.wr_ee_buf_ready = 1'b0; bus.ee_slot_free = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outputs",
        {bus.fdct_go, bus.MB_Col, bus.MB_Row, bus.last_mb_in_row, bus.last_mb_in_pic,
         bus.row_release, bus.pic_done, bus.busy, bus.err_row_ovf}, 0);

    for (int p = 0; p < 5; p++) begin
      run_pic(pics[p].w_m1, pics[p].h_m1, ngo, nrel, ndone, to);
      chk($sformatf("pic%0d_timeout", p), 32'(to), 0);
      chk($sformatf("pic%0d_go_count", p), ngo, pics[p].n_go);
      chk($sformatf("pic%0d_row_release", p), nrel, pics[p].n_rel);
      chk($sformatf("pic%0d_pic_done", p), ndone, 1);
      chk($sformatf("pic%0d_busy_end", p), 32'(bus.busy), 0);
      for (int i = 0; i < pics[p].n_go && i < got_q.size(); i++) begin
        chk($sformatf("pic%0d_go%0d_idx", p, i), 32'(got_q[i]),
            32'({gos[pics[p].go_idx + i].col, gos[pics[p].go_idx + i].row,
                 gos[pics[p].go_idx + i].lr, gos[pics[p].go_idx + i].lp}));
      end
    end

    // ee credit stall: 4x1, no slot frees after two MBs.
    do_reset();
    pulse_row();
    start_pic(8'd3, 8'd0);
    base = go_cnt;
    wait_go(base + 1, "ee_go1");
    mb_hs(1'b0);
    wait_go(base + 2, "ee_go2");
    mb_hs(1'b0);
    repeat (20) tick();
    chk("ee_stall_gos", go_cnt - base, 2);
    bus.ee_slot_free = 1'b1;
    tick();
    bus.ee_slot_free = 1'b0;
    chk("ee_go_not_early", 32'(bus.fdct_go), 0);
    tick();
    chk("ee_go_resume", 32'(bus.fdct_go), 1);
    chk("ee_go_resume_idx", 32'({bus.MB_Col, bus.MB_Row}), 32'({8'd2, 8'd0}));

    // Row stall: 4x2, only one row resident.
    do_reset();
    pulse_row();
    start_pic(8'd3, 8'd1);
    base  = go_cnt;
    rbase = rel_cnt;
    for (int k = 0; k < 4; k++) begin
      wait_go(base + k + 1, $sformatf("row_go%0d", k));
      mb_hs(1'b1);
    end
    repeat (20) tick();
    chk("row_stall_gos", go_cnt - base, 4);
    chk("row_stall_release", rel_cnt - rbase, 1);
    pulse_row();
    chk("row_go_not_early", 32'(bus.fdct_go), 0);
    tick();
    chk("row_go_resume", 32'(bus.fdct_go), 1);
    chk("row_go_resume_idx", 32'({bus.MB_Col, bus.MB_Row}), 32'({8'd0, 8'd1}));

    // Overflow: three rows while idle, credit must hold at two.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse_row();
      chk($sformatf("ovf_err_after_row%0d", i), 32'(bus.err_row_ovf), (i == 2) ? 1 : 0);
    end
    start_pic(8'd0, 8'd2);
    base = go_cnt;
    wait_go(base + 1, "ovf_go1");
    mb_hs(1'b1);
    wait_go(base + 2, "ovf_go2");
    mb_hs(1'b1);
    repeat (20) tick();
    chk("ovf_credit_held_gos", go_cnt - base, 2);
    chk("ovf_err_sticky", 32'(bus.err_row_ovf), 1);
    do_reset();
    chk("ovf_err_cleared_by_rst", 32'(bus.err_row_ovf), 0);

    // Simultaneous row_avail and last-in-row ready_for_next at credit 2.
    pulse_row();
    pulse_row();
    start_pic(8'd0, 8'd2);
    base  = go_cnt;
    dbase = done_cnt;
    wait_go(base + 1, "sim_go1");
    bus.ready_for_next = 1'b1;
    bus.row_avail      = 1'b1;
    tick();
    bus.ready_for_next = 1'b0;
    bus.row_avail      = 1'b0;
    chk("sim_no_err", 32'(bus.err_row_ovf), 0);
    bus.wr_ee_buf_ready = 1'b1;
    tick();
    bus.wr_ee_buf_ready = 1'b0;
    bus.ee_slot_free    = 1'b1;
    tick();
    bus.ee_slot_free    = 1'b0;
    wait_go(base + 2, "sim_go2");
    mb_hs(1'b1);
    wait_go(base + 3, "sim_go3");
    mb_hs(1'b1);
    n = 0;
    while (done_cnt == dbase && n < 50) begin
      tick();
      n++;
    end
    chk("sim_pic_done", done_cnt - dbase, 1);
    chk("sim_err_end", 32'(bus.err_row_ovf), 0);

    // Reset in RUN of the third MB of a 2x2 picture.
    do_reset();
    pulse_row();
    pulse_row();
    start_pic(8'd1, 8'd1);
    base = go_cnt;
    wait_go(base + 1, "rst_go1");
    mb_hs(1'b1);
    wait_go(base + 2, "rst_go2");
    mb_hs(1'b1);
    wait_go(base + 3, "rst_go3");
    chk("rst_pre_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_outputs",
        {bus.fdct_go, bus.MB_Col, bus.MB_Row, bus.last_mb_in_row, bus.last_mb_in_pic,
         bus.row_release, bus.pic_done, bus.busy, bus.err_row_ovf}, 0);

    rst = 1'b1;
    bus.pic_start = 1'b1;
    tick();
    rst = 1'b0;
    bus.pic_start = 1'b0;
    tick();
    chk("rst_beats_pic_start", 32'(bus.busy), 0);

    pulse_row();
    start_pic(8'd1, 8'd1);
    base = go_cnt;
    chk("restart_busy", 32'(bus.busy), 1);
    wait_go(base + 1, "restart_go");
    chk("restart_idx", 32'({bus.MB_Col, bus.MB_Row, bus.last_mb_in_row, bus.last_mb_in_pic}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
